// File: rtl/cpu_pkg.sv
// Shared CPU definitions: command opcodes, default datapath widths and the
// state encoding of the register-file clear scrubber.
package cpu_pkg;

   // Default datapath geometry
   localparam int CPU_DATA_W = 16;
   localparam int CPU_ADDR_W = 4;
   localparam int CPU_IMM_W  = 5;

   // Command opcodes seen on the register-file command port
   localparam logic [2:0] OP_LOAD    = 3'b000;
   localparam logic [2:0] OP_CLEAR   = 3'b110;
   localparam logic [2:0] OP_DISPLAY = 3'b111;

   // Clear scrubber states
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SCRUB = 1'b1
   } scrub_state_t;

endpackage : cpu_pkg

// File: rtl/regfile_scrub_fsm.sv
// Sequential CLEAR scrubber. After start it walks cnt over every register
// index, one per clock, asking the array to zero that entry, then returns to
// IDLE. The last index is detected directly, so cnt never has to overflow.
module regfile_scrub_fsm
   import cpu_pkg::*;
#(
   parameter int ADDR_W = CPU_ADDR_W
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              clr_en,
   output logic [ADDR_W-1:0] clr_idx
);

   scrub_state_t      state;
   scrub_state_t      state_next;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_next;
   logic              last_idx;

   assign last_idx = (cnt == {ADDR_W{1'b1}});

   // State and index registers
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state and index sequencing
   // NOTE: every output of this block gets a default first so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_SCRUB;
               cnt_next   = '0;
            end
         end
         ST_SCRUB: begin
            cnt_next = cnt + ADDR_W'(1);
            if (last_idx) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      busy    = (state == ST_SCRUB);
      clr_en  = (state == ST_SCRUB);
      clr_idx = cnt;
   end

endmodule : regfile_scrub_fsm

// File: rtl/cpu_regfile.sv
// General-purpose register file: two combinational read ports with optional
// same-cycle forwarding, an immediate LOAD / CLEAR / DISPLAY command port and
// an ALU write-back port. While the CLEAR scrubber runs, commands are stalled,
// write-backs are dropped (and flagged) and the read ports return zero.
// IMM_W must not exceed DATA_W; the immediate is zero-extended.
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W = CPU_DATA_W,
   parameter int ADDR_W = CPU_ADDR_W,
   parameter int IMM_W  = CPU_IMM_W,
   parameter bit BYPASS = 1'b1
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [IMM_W-1:0]  cmd_imm,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              busy,
   output logic              wb_drop,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];

   logic              cmd_fire;
   logic              load_hit;
   logic              clear_hit;
   logic              disp_hit;
   logic              wb_ok;
   logic              load_ok;
   logic [DATA_W-1:0] imm_ext;
   logic              clr_en;
   logic [ADDR_W-1:0] clr_idx;

   regfile_scrub_fsm #(
      .ADDR_W (ADDR_W)
   ) u_scrub (
      .clock   (clock),
      .reset   (reset),
      .start   (clear_hit),
      .busy    (busy),
      .clr_en  (clr_en),
      .clr_idx (clr_idx)
   );

   // Commands are stalled for the whole scrub; the producer holds them.
   assign cmd_ready = ~busy;

   // Command decode and write arbitration: write-back beats LOAD on the same
   // address, otherwise both land in the same cycle.
   always_comb begin
      cmd_fire  = cmd_valid & cmd_ready;
      load_hit  = cmd_fire & (cmd_op == OP_LOAD);
      clear_hit = cmd_fire & (cmd_op == OP_CLEAR);
      disp_hit  = cmd_fire & (cmd_op == OP_DISPLAY);
      wb_ok     = wb_en & ~busy;
      load_ok   = load_hit & ~(wb_ok & (wb_addr == cmd_addr));
      imm_ext   = '0;
      imm_ext[IMM_W-1:0] = cmd_imm;
   end

   // Register array: reset clear, scrub clear, then LOAD / write-back
   // NOTE: the array is built from flops with an asynchronous reset because
   // every register must read zero straight out of reset, even mid-scrub; it
   // cannot map onto a plain RAM macro.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (clr_en) begin
         regs[clr_idx] <= '0;
      end else begin
         if (load_ok) begin
            regs[cmd_addr] <= imm_ext;
         end
         if (wb_ok) begin
            regs[wb_addr] <= wb_data;
         end
      end
   end

   // DISPLAY capture: pre-edge register contents, never forwarded
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         disp_data  <= '0;
         disp_valid <= 1'b0;
      end else begin
         disp_valid <= disp_hit;
         if (disp_hit) begin
            disp_data <= regs[cmd_addr];
         end
      end
   end

   // Flag a write-back that arrived while the scrubber owned the array
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb_drop <= 1'b0;
      end else begin
         wb_drop <= wb_en & busy;
      end
   end

   // Read ports: array value, optionally overridden by this cycle's winning
   // write, and forced to zero while scrubbing or in reset
   always_comb begin
      rd_data_a = regs[rd_addr_a];
      rd_data_b = regs[rd_addr_b];
      if (BYPASS) begin
         if (load_ok && (cmd_addr == rd_addr_a)) begin
            rd_data_a = imm_ext;
         end
         if (wb_ok && (wb_addr == rd_addr_a)) begin
            rd_data_a = wb_data;
         end
         if (load_ok && (cmd_addr == rd_addr_b)) begin
            rd_data_b = imm_ext;
         end
         if (wb_ok && (wb_addr == rd_addr_b)) begin
            rd_data_b = wb_data;
         end
      end
      if (busy || reset) begin
         rd_data_a = '0;
         rd_data_b = '0;
      end
   end

endmodule : cpu_regfile

// File: tb/tb_cpu_regfile.sv
// Self-checking bench for cpu_regfile (default geometry, BYPASS=1). A
// behavioural model keeps the register contents as a plain array and the
// scrub as a count of remaining cycles; reads with forwarding are simply the
// post-write array value.
module tb_cpu_regfile;

   localparam int DEPTH = 16;
   localparam logic [2:0] C_LOAD    = 3'b000;
   localparam logic [2:0] C_CLEAR   = 3'b110;
   localparam logic [2:0] C_DISPLAY = 3'b111;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [3:0]  cmd_addr = '0;
   logic [4:0]  cmd_imm = '0;
   logic        wb_en = 1'b0;
   logic [3:0]  wb_addr = '0;
   logic [15:0] wb_data = '0;
   logic [3:0]  rd_addr_a = '0;
   logic [3:0]  rd_addr_b = '0;
   logic [15:0] rd_data_a;
   logic [15:0] rd_data_b;
   logic        busy;
   logic        wb_drop;
   logic [15:0] disp_data;
   logic        disp_valid;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   cpu_regfile #(
      .DATA_W (16),
      .ADDR_W (4),
      .IMM_W  (5),
      .BYPASS (1'b1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_addr   (cmd_addr),
      .cmd_imm    (cmd_imm),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .rd_data_a  (rd_data_a),
      .rd_data_b  (rd_data_b),
      .busy       (busy),
      .wb_drop    (wb_drop),
      .disp_data  (disp_data),
      .disp_valid (disp_valid)
   );

   // ---------------- reference model ----------------
   logic [15:0] m_mem [DEPTH];
   int          m_left;
   int          m_idx;
   logic [15:0] m_disp;
   logic        m_dv;
   logic        m_drop;

   logic [15:0] n_mem [DEPTH];
   int          n_left;
   int          n_idx;
   logic [15:0] n_disp;
   logic        n_dv;
   logic        n_drop;

   logic [15:0] e_rd_a;
   logic [15:0] e_rd_b;
   logic        e_busy;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_left = 0;
      m_idx  = 0;
      m_disp = '0;
      m_dv   = 1'b0;
      m_drop = 1'b0;
   endtask

   // Drive one cycle of inputs and predict both the combinational outputs of
   // this cycle and the state after the coming edge.
   task automatic apply(input logic v, input logic [2:0] op, input logic [3:0] ca,
                        input logic [4:0] imm, input logic we, input logic [3:0] wa,
                        input logic [15:0] wd, input logic [3:0] ra, input logic [3:0] rb);
      cmd_valid = v;   cmd_op = op;   cmd_addr = ca;  cmd_imm = imm;
      wb_en = we;      wb_addr = wa;  wb_data = wd;
      rd_addr_a = ra;  rd_addr_b = rb;
      e_busy = (m_left > 0);
      n_mem  = m_mem;
      n_left = m_left;
      n_idx  = m_idx;
      n_disp = m_disp;
      n_dv   = 1'b0;
      n_drop = we && e_busy;
      if (e_busy) begin
         n_mem[m_idx] = '0;
         n_idx  = m_idx + 1;
         n_left = m_left - 1;
      end else begin
         if (v) begin
            case (op)
               C_LOAD:    n_mem[ca] = 16'(imm);
               C_CLEAR:   begin n_left = DEPTH; n_idx = 0; end
               C_DISPLAY: begin n_disp = m_mem[ca]; n_dv = 1'b1; end
               default:   ;
            endcase
         end
         if (we) n_mem[wa] = wd;
      end
      e_rd_a = e_busy ? 16'h0 : n_mem[ra];
      e_rd_b = e_busy ? 16'h0 : n_mem[rb];
      #1;
   endtask

   task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
      apply(1'b0, 3'b001, 4'd0, 5'd0, 1'b0, 4'd0, 16'h0, ra, rb);
   endtask

   // Advance one clock and commit the prediction.
   task automatic tick();
      @(posedge clock);
      #1;
      m_mem  = n_mem;
      m_left = n_left;
      m_idx  = n_idx;
      m_disp = n_disp;
      m_dv   = n_dv;
      m_drop = n_drop;
   endtask

   // ---------------- scenarios ----------------
   task automatic check_all_zero(input string tag);
      for (int i = 0; i < DEPTH; i += 2) begin
         idle(4'(i), 4'(i + 1));
         total++;
         if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
            bad++;
            $display("FAIL %s r%0d/r%0d got=%h/%h want=0000/0000", tag, i, i + 1, rd_data_a, rd_data_b);
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      model_reset();
      idle(4'd3, 4'd0);
      @(posedge clock);
      #2;
      total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || disp_valid !== 1'b0 || wb_drop !== 1'b0 ||
          disp_data !== 16'h0 || rd_data_a !== 16'h0) begin
         bad++;
         $display("FAIL reset_state got busy=%b rdy=%b dv=%b drop=%b disp=%h rd=%h want 0 1 0 0 0000 0000",
                  busy, cmd_ready, disp_valid, wb_drop, disp_data, rd_data_a);
      end
      reset = 1'b0;
      // LOAD r3 = 21, forwarded in the same cycle and stored afterwards
      apply(1'b1, C_LOAD, 4'd3, 5'd21, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3);
      total++;
      if (rd_data_a !== 16'h0015) begin
         bad++;
         $display("FAIL load_bypass got=%h want=0015", rd_data_a);
      end
      tick();
      idle(4'd3, 4'd0);
      total++;
      if (rd_data_a !== 16'h0015) begin
         bad++;
         $display("FAIL load_r3 got=%h want=0015", rd_data_a);
      end
      tick();
      // populate, then reset in the middle of a run
      for (int i = 0; i < 6; i++) begin
         apply(1'b0, C_LOAD, 4'd0, 5'd0, 1'b1, 4'(i * 2 + 1), 16'($urandom) | 16'h1, 4'd0, 4'd0);
         tick();
      end
      reset = 1'b1;
      model_reset();
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_all_zero("reset_regs");
   endtask

   task automatic test_wb_priority();
      apply(1'b1, C_LOAD, 4'd7, 5'd3, 1'b1, 4'd7, 16'hBEEF, 4'd0, 4'd7);
      total++;
      if (rd_data_b !== 16'hBEEF) begin
         bad++;
         $display("FAIL wb_bypass got=%h want=beef", rd_data_b);
      end
      tick();
      idle(4'd0, 4'd7);
      total++;
      if (rd_data_b !== 16'hBEEF) begin
         bad++;
         $display("FAIL wb_wins got=%h want=beef", rd_data_b);
      end
      tick();
      // different addresses: both writes land
      apply(1'b1, C_LOAD, 4'd2, 5'd9, 1'b1, 4'd4, 16'h4444, 4'd2, 4'd4);
      total++;
      if (rd_data_a !== 16'h0009 || rd_data_b !== 16'h4444) begin
         bad++;
         $display("FAIL dual_bypass got=%h/%h want=0009/4444", rd_data_a, rd_data_b);
      end
      tick();
      idle(4'd2, 4'd4);
      total++;
      if (rd_data_a !== 16'h0009 || rd_data_b !== 16'h4444) begin
         bad++;
         $display("FAIL dual_write got=%h/%h want=0009/4444", rd_data_a, rd_data_b);
      end
      tick();
   endtask

   task automatic run_clear(input string tag);
      int busy_cycles = 0;
      int guard = 0;
      apply(1'b1, C_CLEAR, 4'd0, 5'd0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      tick();
      while (busy === 1'b1 && guard < 40) begin
         idle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         busy_cycles++;
         total++;
         if (cmd_ready !== 1'b0 || rd_data_a !== 16'h0 || rd_data_b !== 16'h0 || e_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_busy_window cyc=%0d got rdy=%b rd=%h/%h model_busy=%b want rdy=0 rd=0000/0000 model_busy=1",
                     tag, busy_cycles, cmd_ready, rd_data_a, rd_data_b, e_busy);
         end
         tick();
         guard++;
      end
      total++;
      if (busy_cycles != DEPTH || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s_length got=%0d rdy=%b want=%0d rdy=1", tag, busy_cycles, cmd_ready, DEPTH);
      end
   endtask

   task automatic test_clear();
      for (int i = 0; i < DEPTH; i++) begin
         apply(1'b0, C_LOAD, 4'd0, 5'd0, 1'b1, 4'(i), 16'hA000 + 16'(i), 4'd0, 4'd0);
         tick();
      end
      idle(4'd15, 4'd6);
      total++;
      if (rd_data_a !== 16'hA00F || rd_data_b !== 16'hA006) begin
         bad++;
         $display("FAIL fill got=%h/%h want=a00f/a006", rd_data_a, rd_data_b);
      end
      tick();
      run_clear("clear");
      check_all_zero("clear_regs");
   endtask

   task automatic test_wb_during_scrub();
      int guard = 0;
      int waited = 0;
      apply(1'b1, C_CLEAR, 4'd0, 5'd0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      tick();
      for (int c = 0; c < 12; c++) begin
         idle(4'd0, 4'd0);
         tick();
      end
      // index 2 is already scrubbed; this write must be dropped
      apply(1'b0, C_LOAD, 4'd0, 5'd0, 1'b1, 4'd2, 16'hFFFF, 4'd2, 4'd2);
      tick();
      total++;
      if (wb_drop !== 1'b1) begin
         bad++;
         $display("FAIL wb_drop_pulse got=%b want=1", wb_drop);
      end
      // hold a LOAD r2=17 until it is accepted
      apply(1'b1, C_LOAD, 4'd2, 5'd17, 1'b0, 4'd0, 16'h0, 4'd2, 4'd2);
      while (e_busy && guard < 40) begin
         tick();
         if (guard == 0) begin
            total++;
            if (wb_drop !== 1'b0) begin
               bad++;
               $display("FAIL wb_drop_width got=%b want=0", wb_drop);
            end
         end
         apply(1'b1, C_LOAD, 4'd2, 5'd17, 1'b0, 4'd0, 16'h0, 4'd2, 4'd2);
         waited++;
         guard++;
      end
      total++;
      if (cmd_ready !== 1'b1 || rd_data_a !== 16'h0011 || waited != 3) begin
         bad++;
         $display("FAIL held_load_accept got rdy=%b rd=%h waited=%0d want rdy=1 rd=0011 waited=3",
                  cmd_ready, rd_data_a, waited);
      end
      tick();
      idle(4'd2, 4'd0);
      total++;
      if (rd_data_a !== 16'h0011 || busy !== 1'b0) begin
         bad++;
         $display("FAIL held_load_data got=%h busy=%b want=0011 busy=0", rd_data_a, busy);
      end
      tick();
   endtask

   task automatic test_display();
      apply(1'b0, C_LOAD, 4'd0, 5'd0, 1'b1, 4'd5, 16'h1234, 4'd0, 4'd0);
      tick();
      apply(1'b1, C_DISPLAY, 4'd5, 5'd0, 1'b1, 4'd5, 16'h9999, 4'd5, 4'd0);
      tick();
      total++;
      if (disp_valid !== 1'b1 || disp_data !== 16'h1234) begin
         bad++;
         $display("FAIL display_capture got dv=%b data=%h want dv=1 data=1234", disp_valid, disp_data);
      end
      idle(4'd5, 4'd0);
      total++;
      if (rd_data_a !== 16'h9999) begin
         bad++;
         $display("FAIL display_wb got=%h want=9999", rd_data_a);
      end
      tick();
      total++;
      if (disp_valid !== 1'b0 || disp_data !== 16'h1234) begin
         bad++;
         $display("FAIL display_pulse got dv=%b data=%h want dv=0 data=1234", disp_valid, disp_data);
      end
   endtask

   task automatic test_reset_mid_scrub();
      for (int i = 0; i < DEPTH; i++) begin
         apply(1'b0, C_LOAD, 4'd0, 5'd0, 1'b1, 4'(i), 16'h5A00 | 16'(i), 4'd0, 4'd0);
         tick();
      end
      apply(1'b1, C_CLEAR, 4'd0, 5'd0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
      tick();
      for (int c = 0; c < 6; c++) begin
         idle(4'd0, 4'd0);
         tick();
      end
      idle(4'd9, 4'd12);
      reset = 1'b1;
      model_reset();
      #1;
      total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || rd_data_a !== 16'h0 || rd_data_b !== 16'h0) begin
         bad++;
         $display("FAIL scrub_reset got busy=%b rdy=%b rd=%h/%h want 0 1 0000/0000",
                  busy, cmd_ready, rd_data_a, rd_data_b);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      check_all_zero("scrub_reset_regs");
      run_clear("clear_after_reset");
   endtask

   task automatic test_random();
      logic [2:0] op;
      int r;
      for (int cyc = 0; cyc < 400; cyc++) begin
         r = $urandom_range(0, 39);
         if (r < 18)      op = C_LOAD;
         else if (r < 26) op = C_DISPLAY;
         else if (r == 39) op = C_CLEAR;
         else             op = 3'($urandom_range(1, 5));
         apply(1'($urandom_range(0, 1)), op, 4'($urandom), 5'($urandom), 1'($urandom_range(0, 1)),
               4'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
         total++;
         if (rd_data_a !== e_rd_a || rd_data_b !== e_rd_b || busy !== e_busy || cmd_ready !== !e_busy) begin
            bad++;
            $display("FAIL rand_comb cyc=%0d got rd=%h/%h busy=%b rdy=%b want rd=%h/%h busy=%b rdy=%b",
                     cyc, rd_data_a, rd_data_b, busy, cmd_ready, e_rd_a, e_rd_b, e_busy, !e_busy);
         end
         tick();
         total++;
         if (disp_valid !== m_dv || disp_data !== m_disp || wb_drop !== m_drop) begin
            bad++;
            $display("FAIL rand_reg cyc=%0d got dv=%b disp=%h drop=%b want dv=%b disp=%h drop=%b",
                     cyc, disp_valid, disp_data, wb_drop, m_dv, m_disp, m_drop);
         end
      end
   endtask

   initial begin
      test_reset();
      test_wb_priority();
      test_clear();
      test_wb_during_scrub();
      test_display();
      test_reset_mid_scrub();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cpu_regfile

// File: doc/cpu_regfile.md
# cpu_regfile

Parametrised general-purpose register file for the CPU datapath. It provides two combinational read ports, an immediate-load command port and an ALU write-back port. It also runs a multi-cycle sequential CLEAR scrubber and a registered DISPLAY capture. It sits between instruction decode (command port) and the ALU (read ports, write-back port).

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, register address width; DEPTH = 2**ADDR_W registers
- IMM_W, 5, immediate width; must satisfy IMM_W <= DATA_W
- BYPASS, 1, 1 = read ports forward same-cycle writes; 0 = no forwarding
- clock  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  LOAD=3'b000, CLEAR=3'b110, DISPLAY=3'b111; other codes are no-ops
- cmd_addr  in  ADDR_W  target register for LOAD/DISPLAY
- cmd_imm  in  IMM_W  immediate for LOAD
- wb_en  in  1  ALU write-back strobe
- wb_addr  in  ADDR_W  write-back register
- wb_data  in  DATA_W  write-back value
- rd_addr_a / rd_addr_b  in  ADDR_W  read addresses
- rd_data_a / rd_data_b  out  DATA_W  read data
- busy  out  1  CLEAR scrub in progress
- wb_drop  out  1  one-cycle pulse: write-back discarded because busy
- disp_data  out  DATA_W  last captured DISPLAY value
- disp_valid  out  1  one-cycle pulse when disp_data updates

## Operation
- Accepted LOAD: reg[cmd_addr] <= zero-extended cmd_imm.
- wb_en=1 while not busy: reg[wb_addr] <= wb_data.
- LOAD and write-back to the same address in the same cycle: write-back wins. Different addresses: both writes occur.
- Accepted DISPLAY: disp_data <= reg[cmd_addr], using the pre-edge value with no forwarding; disp_valid pulses.
- Accepted CLEAR: FSM goes IDLE -> SCRUB with cnt=0.
  - In SCRUB, each edge does reg[cnt] <= 0 and cnt++.
  - After clearing index DEPTH-1, the FSM returns to IDLE.
- busy = (state==SCRUB). cmd_ready = ~busy.
- wb_en while busy: write is ignored and wb_drop pulses on the next cycle.
- Read ports while busy return 0 regardless of array contents.
- BYPASS=1 and not busy: if a write (winning source) targets rd_addr_x this cycle, rd_data_x returns the write data. Otherwise rd_data_x = reg[rd_addr_x].
- Unknown cmd_op: accepted, no effect.
- Reset (any time, including mid-scrub):
  - all registers = 0
  - state = IDLE, cnt = 0
  - busy = 0, cmd_ready = 1
  - disp_data = 0, disp_valid = 0, wb_drop = 0
  - rd_data = 0

## Timing
- Read ports are combinational: 0-cycle latency.
- LOAD and write-back values are visible on the read ports the cycle after the edge. With BYPASS=1 they are visible in the same cycle.
- DISPLAY: disp_data and disp_valid are valid the cycle after acceptance.
- CLEAR accepted at edge N:
  - busy is high from cycles N+1 through N+DEPTH.
  - Register i is cleared at edge N+1+i.
  - cmd_ready returns high after edge N+DEPTH.
- A command presented while busy is held by the producer; it is not lost.
- cnt wraps to 0 after DEPTH-1; the end of scrub is detected on cnt==DEPTH-1, not on overflow.

## Structure
- Shared package cpu_pkg holds the opcode constants (OP_LOAD, OP_CLEAR, OP_DISPLAY) and the default DATA_W, ADDR_W and IMM_W.
- Sub-module regfile_scrub_fsm: the IDLE/SCRUB state, cnt, busy and the clear-enable/index outputs.
- The array, write arbitration, bypass and display capture stay in cpu_regfile.

## Test plan
- Reset, then LOAD r3 imm=5'd21, then read a=r3 -> rd_data_a=16'h0015 the next cycle. Release reset mid-run and confirm all registers read 0.
- Same cycle: wb_en r7=16'hBEEF and LOAD r7 imm=3 -> r7=16'hBEEF. With BYPASS=1 and rd_addr_b=r7, rd_data_b=16'hBEEF in the same cycle.
- Fill r0..r15 with distinct values, then CLEAR:
  - busy high for exactly 16 cycles
  - cmd_ready low over the same window
  - rd_data=0 while busy
  - all registers 0 afterwards
- wb_en during SCRUB -> wb_drop pulses one cycle and the target is still 0 after scrub. LOAD held with cmd_valid during SCRUB is accepted the first cycle cmd_ready=1.
- r5=16'h1234, then DISPLAY r5 and wb r5=16'h9999 in the same cycle -> disp_data=16'h1234 and disp_valid a one-cycle pulse.
- Assert reset at scrub cycle 6 -> busy=0 immediately and all registers 0. A new CLEAR then runs a full 16 cycles.
